// File: rtl/rr_grant_scheduler_if.sv
// rr_grant_scheduler_if
//   Request/grant bundle for the round-robin grant scheduler.
//   req     : 4 request lines, bit i belongs to requester i (level-sensitive)
//   gnt     : registered one-hot grant, all-zero when nobody owns the resource
//   gnt_id  : registered index of the current (or most recent) owner
//   expired : one-cycle pulse on the cycle after a hold-timeout release
//
// Handshake: a requester raises req[i] and keeps it high for as long as it
// wants the resource. gnt[i] is the acknowledgment and stays high while the
// requester keeps req[i] high, up to MAX_HOLD cycles. Dropping req[i] is the
// release. There is no valid/ready pair because the grant is not a data transfer.
interface rr_grant_scheduler_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       expired;

  modport master (output req, input gnt, input gnt_id, input expired);
  modport slave  (input req, output gnt, output gnt_id, output expired);
endinterface

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler
//   Four-requester round-robin arbiter with a bounded hold time and one
//   dead cycle between consecutive grants.
//   clock     : single clock, rising edge
//   reset     : synchronous, active-low
//   bus       : rr_grant_scheduler_if.slave (req in; gnt, gnt_id, expired out)
//   state_dbg : current one-hot FSM state (IDLE=001, GRANT=010, GAP=100)
module rr_grant_scheduler #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  rr_grant_scheduler_if.slave  bus,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    GRANT = 3'b010,
    GAP   = 3'b100
  } state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] hold_cnt;

  // Round-robin search: the first set request at or above ptr (mod 4) wins.
  // The loop runs from the farthest candidate down to ptr itself, so the
  // last match written is the closest one.
  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_id    = ptr;
    cand      = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (bus.req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      bus.gnt     <= 4'b0000;
      bus.gnt_id  <= 2'd0;
      bus.expired <= 1'b0;
      hold_cnt    <= 4'd0;
      ptr         <= 2'd0;
    end else begin
      bus.expired <= 1'b0;
      case (state)
        // IDLE and GAP arbitrate the same way; GAP only exists to force the
        // dead cycle after a release.
        IDLE, GAP: begin
          if (win_found) begin
            state      <= GRANT;
            bus.gnt    <= 4'b0001 << win_id;
            bus.gnt_id <= win_id;
            hold_cnt   <= 4'd1;
          end else begin
            state   <= IDLE;
            bus.gnt <= 4'b0000;
          end
        end
        GRANT: begin
          if (bus.req[bus.gnt_id] && (hold_cnt < MAX_HOLD_C)) begin
            hold_cnt <= hold_cnt + 4'd1;
          end else begin
            // Release: voluntary when the owner dropped req (even on the
            // last allowed cycle), forced when it is still requesting.
            state       <= GAP;
            bus.gnt     <= 4'b0000;
            ptr         <= bus.gnt_id + 2'd1;
            hold_cnt    <= 4'd0;
            bus.expired <= bus.req[bus.gnt_id];
          end
        end
        default: begin
          state       <= IDLE;
          bus.gnt     <= 4'b0000;
          bus.expired <= 1'b0;
        end
      endcase
    end
  end

endmodule
